// File: rtl/des_pkg.sv
// DES key schedule shared tables, state encoding and helpers.
// Bit n in DES notation is the MSB-first position n of each vector.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    FIN
  } state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  // Decrypt walks the encrypt shifts backwards; round 0 uses C0/D0 as is.
  function automatic logic [1:0] shift_amt(
    input logic       dec,
    input logic [3:0] idx
  );
    if (!dec) return SHIFTS[idx];
    if (idx == 4'd0) return 2'd0;
    return SHIFTS[4'd0 - idx];
  endfunction

  function automatic logic [27:0] rot28(
    input logic [27:0] x,
    input logic [1:0]  n,
    input logic        right
  );
    if (right) begin
      if (n == 2'd2) return {x[1:0], x[27:2]};
      if (n == 2'd1) return {x[0], x[27:1]};
    end else begin
      if (n == 2'd2) return {x[25:0], x[27:26]};
      if (n == 2'd1) return {x[26:0], x[27]};
    end
    return x;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: 56-bit C||D to 48-bit round key.
// Purely combinational.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] key
);

  always_comb begin
    key = '0;
    for (int i = 0; i < 48; i++) key[47-i] = cd[56-PC2[i]];
  end

  // C/D bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31],
                       cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_sched.sv
// DES round-key generator with valid/ready key stream, encrypt/decrypt order.
// Optional key byte parity check: define DES_KEY_PARITY_CHK_EN.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        start,
  input  logic        decrypt,
  output logic        ready,
  output logic [47:0] key_dat,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [3:0]  key_round,
  output logic        done,
  output logic        parity_err
);

  state_t      state;
  logic [27:0] c, d;
  logic [27:0] c_nxt, d_nxt;
  logic        dec;
  logic        first;
  logic [3:0]  idx_nxt;
  logic [1:0]  amt;
  logic [47:0] k_nxt;
  logic [55:0] cd0;

  assign cd0     = pc1(key_in);
  assign idx_nxt = first ? 4'd0 : key_round + 4'd1;
  assign amt     = shift_amt(dec, idx_nxt);
  assign c_nxt   = rot28(c, amt, dec);
  assign d_nxt   = rot28(d, amt, dec);

  des_pc2 u_pc2 (
    .cd  ({c_nxt, d_nxt}),
    .key (k_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      key_valid <= 1'b0;
      done      <= 1'b0;
      key_round <= 4'd0;
      key_dat   <= '0;
      c         <= '0;
      d         <= '0;
      dec       <= 1'b0;
      first     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            c     <= cd0[55:28];
            d     <= cd0[27:0];
            dec   <= decrypt;
            first <= 1'b1;
            ready <= 1'b0;
            state <= GEN;
          end
        end
        GEN: begin
          // First GEN cycle loads round 0; afterwards advance per handshake.
          if (first) begin
            c         <= c_nxt;
            d         <= d_nxt;
            key_dat   <= k_nxt;
            key_round <= 4'd0;
            key_valid <= 1'b1;
            first     <= 1'b0;
          end else if (key_ready) begin
            if (key_round == 4'd15) begin
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              c         <= c_nxt;
              d         <= d_nxt;
              key_dat   <= k_nxt;
              key_round <= idx_nxt;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  logic [7:0] byte_odd;

  always_comb begin
    byte_odd = '0;
    for (int b = 0; b < 8; b++) byte_odd[b] = ^key_in[8*b +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else if (state == IDLE && start) parity_err <= ~&byte_odd;
  end
`else
  assign parity_err = 1'b0;

  // Parity bits are discarded by PC-1 when the check is absent.
  logic unused_par;
  assign unused_par = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                        key_in[24], key_in[16], key_in[8], key_in[0]};
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched.
// Honours DES_KEY_PARITY_CHK_EN for parity_err expectations.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        start;
  logic        decrypt;
  logic        ready;
  logic [47:0] key_dat;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_round;
  logic        done;
  logic        parity_err;

  des_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .start      (start),
    .decrypt    (decrypt),
    .ready      (ready),
    .key_dat    (key_dat),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_round  (key_round),
    .done       (done),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

`ifdef DES_KEY_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int M_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct {
    logic [3:0]  rnd;
    logic [47:0] key;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          kv_on = 1'b0;
  logic [47:0] kv0, kv15;
  logic [47:0] last_acc = '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Encrypt key for round r from the total left shift applied to C0/D0.
  function automatic logic [47:0] ref_key(logic [63:0] k, int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] o;
    int          tot;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-M_PC1[i]];
    c   = cd[55:28];
    d   = cd[27:0];
    tot = 0;
    for (int i = 0; i <= r; i++) tot += M_SH[i];
    for (int j = 0; j < tot; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-M_PC2[i]];
    return o;
  endfunction

  task automatic push_sched(logic [63:0] k, logic dec);
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      e.rnd = 4'(r);
      e.key = dec ? ref_key(k, 15 - r) : ref_key(k, r);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("key_dat", 64'(key_dat), 64'(e.key));
        check("key_round", 64'(key_round), 64'(e.rnd));
        last_acc = key_dat;
        if (kv_on && key_round == 4'd0) check("kv_r0", 64'(key_dat), 64'(kv0));
        if (kv_on && key_round == 4'd15) check("kv_r15", 64'(key_dat), 64'(kv15));
      end
    end
  end

  task automatic do_start(logic [63:0] k, logic dec);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_pre", 64'(ready), 64'd1);
    key_in  = k;
    decrypt = dec;
    start   = 1'b1;
    push_sched(k, dec);
    @(posedge clk); #1;
    start   = 1'b0;
    key_in  = ~k;
    decrypt = ~dec;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic post_done();
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("ready_idle", 64'(ready), 64'd1);
    check("hold_dat", 64'(key_dat), 64'(last_acc));
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_round(logic [3:0] r);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(key_valid && key_round == r) && n < 60);
    check("round_seen", 64'(key_round), 64'(r));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [47:0] hold;
    rst = 1'b1; start = 1'b0; decrypt = 1'b0;
    key_ready = 1'b1; key_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(key_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round", 64'(key_round), 64'd0);
    check("rst_dat", 64'(key_dat), 64'd0);
    check("rst_par", 64'(parity_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Encrypt known vector, latency and timing
    kv_on = 1'b1; kv0 = K1_A; kv15 = K16_A;
    do_start(KEY_A, 1'b0);
    @(negedge clk);
    check("t1_valid0", 64'(key_valid), 64'd0);
    check("t1_busy", 64'(ready), 64'd0);
    @(negedge clk);
    check("t1_valid1", 64'(key_valid), 64'd1);
    check("t1_round0", 64'(key_round), 64'd0);
    wait_done(2, n);
    check("enc_latency", 64'(n - 1), 64'd17);
    post_done();

    // Decrypt known vector
    kv0 = K16_A; kv15 = K1_A;
    do_start(KEY_A, 1'b1);
    wait_done(0, n);
    check("dec_latency", 64'(n - 1), 64'd17);
    post_done();
    kv_on = 1'b0;

    // Back-pressure at round 3
    do_start(64'h0123456789ABCDEF, 1'b0);
    wait_round(4'd3);
    key_ready = 1'b0;
    hold = key_dat;
    repeat (5) begin
      @(negedge clk);
      check("stall_round", 64'(key_round), 64'd3);
      check("stall_dat", 64'(key_dat), 64'(hold));
      check("stall_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    key_ready = 1'b1;
    wait_done(0, n);
    post_done();

    // Reset in the middle of a schedule
    do_start(64'hFEDCBA9876543210, 1'b1);
    wait_round(4'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(key_valid), 64'd0);
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_round", 64'(key_round), 64'd0);
    check("mid_rst_dat", 64'(key_dat), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_resume", 64'(key_valid), 64'd0);
    end
    kv_on = 1'b1; kv0 = K1_A; kv15 = K16_A;
    do_start(KEY_A, 1'b0);
    wait_done(0, n);
    check("restart_latency", 64'(n - 1), 64'd17);
    post_done();
    kv_on = 1'b0;

    // Start pulse during GEN must be ignored
    do_start(64'h0E329232EA6D0D73, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    key_in = 64'hA5A5A5A55A5A5A5A; decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, n);
    post_done();

    // Parity check
    do_start(64'h133457799BBCDFF0, 1'b0);
    @(negedge clk);
    check("par_bad", 64'(parity_err), 64'(PAR_EN));
    wait_done(1, n);
    post_done();
    check("par_hold", 64'(parity_err), 64'(PAR_EN));
    do_start(KEY_A, 1'b0);
    @(negedge clk);
    check("par_good", 64'(parity_err), 64'd0);
    wait_done(1, n);
    post_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-003 SHALL have port key_in, input, 64 bits: DES key; bit 1 in DES notation is key_in[63].
REQ-004 SHALL have port start, input, 1 bit: request a new schedule; sampled only while ready=1.
REQ-005 SHALL have port decrypt, input, 1 bit: 0 emits K1..K16, 1 emits K16..K1; sampled with start.
REQ-006 SHALL have port ready, output, 1 bit: high in IDLE only.
REQ-007 SHALL have port key_dat, output, 48 bits: current round key, feeds the round function key_dat input.
REQ-008 SHALL have port key_valid, output, 1 bit: key_dat and key_round are valid.
REQ-009 SHALL have port key_ready, input, 1 bit: consumer accepts key_dat when key_valid=1 and key_ready=1.
REQ-010 SHALL have port key_round, output, 4 bits: emission index 0..15 of key_dat.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the 16th key is accepted.
REQ-012 SHALL have port parity_err, output, 1 bit: key byte parity failure (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, GEN, FIN.
REQ-014 SHALL, in IDLE with start=1, latch PC-1(key_in) into 28-bit C/D registers, latch decrypt, and enter GEN next cycle.
REQ-015 SHALL apply encrypt shifts s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 as left rotations, with Ki = PC-2(Ci,Di).
REQ-016 SHALL, in decrypt mode, emit PC-2(C0,D0) as round 0 and then apply right rotations 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before rounds 1..15.
REQ-017 SHALL drive key_dat, key_valid and key_round from registers; a start accepted at edge T gives key_valid=1, key_round=0 after edge T+1.
REQ-018 SHALL hold key_dat and key_round stable while key_valid=1 and key_ready=0; no skipped or repeated rounds.
REQ-019 SHALL present the next key in the cycle after a handshake (1 key/cycle when key_ready stays high).
REQ-020 SHALL, on handshake at key_round=15, enter FIN: key_valid=0, done=1 for one cycle, then return to IDLE.
REQ-021 SHALL ignore start outside IDLE; key_in changes after acceptance SHALL NOT affect the schedule.
REQ-022 SHALL keep key_dat at its last value when key_valid=0.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-schedule, force IDLE and set ready=1, key_valid=0, done=0, key_round=0, key_dat=0, parity_err=0, C/D=0.
REQ-024 SHALL, after rst deasserts, require a new start; an interrupted schedule SHALL NOT resume.

Configuration
REQ-025 SHALL, with DES_KEY_PARITY_CHK_EN defined, check on start acceptance that each key_in byte has odd parity and register parity_err; the value holds until the next accepted start or reset, and the schedule still runs.
REQ-026 SHALL, without DES_KEY_PARITY_CHK_EN, tie parity_err to 0 and include no parity logic.

Structure
REQ-027 SHALL place the PC-1 table, PC-2 table, shift schedule and state encodings in shared package des_pkg.
REQ-028 SHALL instantiate one combinational sub-module des_pc2 (56-bit C||D in, 48-bit key out); PC-1 and rotation stay inline.

Verification
REQ-029 SHALL cover: key_in=0x133457799BBCDFF1, decrypt=0, key_ready=1 -> round 0 key_dat=0x1B02EFFC7072, round 15 0xCB3D8B0E17F5, done 17 cycles after start.
REQ-030 SHALL cover: same key, decrypt=1 -> round 0 0xCB3D8B0E17F5, round 15 0x1B02EFFC7072; full sequence equals the reversed encrypt sequence.
REQ-031 SHALL cover: key_ready held low 5 cycles at key_round=3 -> key_dat/key_round stable, no done, sequence continues at round 4.
REQ-032 SHALL cover: rst pulse at key_round=7 -> key_valid=0 and ready=1 immediately; next start restarts at round 0.
REQ-033 SHALL cover: start pulsed during GEN with another key -> ignored, output sequence unchanged.
REQ-034 SHALL cover, with DES_KEY_PARITY_CHK_EN: key 0x133457799BBCDFF1 -> parity_err=0; key 0x133457799BBCDFF0 -> parity_err=1.
